multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 48 ++++
 rtl/multicycle_control_mem_wait_timer.sv | 46 ++++
 rtl/multicycle_control.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_pkg
//   Shared types and constants for the multicycle datapath controller:
//   opcode type and opcode constants, the controller state enum, and the
//   encodings of the ALU-control class and the PC / ALU-B mux selects.
// -----------------------------------------------------------------------------
package multicycle_control_pkg;

    typedef logic [5:0] opcode_type;

    localparam opcode_type OP_RTYPE = 6'b000000;
    localparam opcode_type OP_LW    = 6'b100011;
    localparam opcode_type OP_SW    = 6'b101011;
    localparam opcode_type OP_BEQ   = 6'b000100;
    localparam opcode_type OP_J     = 6'b000010;

    // The numeric values are what state_dbg shows.
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        TRAP      = 4'd10
    } ctrl_state_type;

    // ALU-control class
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] ALU_B_REG   = 2'b00;
    localparam logic [1:0] ALU_B_FOUR  = 2'b01;
    localparam logic [1:0] ALU_B_IMM   = 2'b10;
    localparam logic [1:0] ALU_B_SHIMM = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
//   Counts wait cycles of one memory access.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   clear_i  : zero the count (the controller is entering a new state)
//   count_i  : this cycle is a wait cycle (access pending, mem_ready low)
//   limit_o  : the current wait cycle is the LIMIT-th consecutive one
// -----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_i,
    output logic limit_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count holds the number of wait cycles already spent, so the
    // LIMIT-th wait cycle is the one where it equals LIMIT-1.
    assign limit_o = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Control FSM of a multicycle lw/sw/R-type/beq/j datapath.
//   clk, rst_n      : clock, asynchronous active-low reset
//   op              : opcode field of the instruction register
//   mem_ready       : memory access completes this cycle
//   hold            : freezes the controller while it is in FETCH
//   datapath strobes: pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
//                     mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a,
//                     pc_source, alu_src_b, alu_op
//   illegal_op      : sticky, set when an undecoded opcode reaches DECODE
//   mem_timeout     : sticky, set when a memory access waits too long
//   instr_count     : retired-instruction counter (wraps)
//   state_dbg       : current state encoding
// -----------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  opcode_type  op,
    input  logic        mem_ready,
    input  logic        hold,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  pc_source,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        illegal_op,
    output logic        mem_timeout,
    output logic [31:0] instr_count,
    output logic [3:0]  state_dbg
);

    ctrl_state_type state_q, state_d;
    logic           illegal_q, timeout_q;
    logic [31:0]    instr_count_q;

    logic retire;
    logic set_illegal;
    logic set_timeout;
    logic wait_cycle;
    logic limit_hit;

    // Any state change clears the wait count, which covers every entry
    // into FETCH, MEM_READ and MEM_WRITE.
    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_d != state_q),
        .count_i (wait_cycle),
        .limit_o (limit_hit)
    );

    // State and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            illegal_q     <= 1'b0;
            timeout_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
            if (retire)      instr_count_q <= instr_count_q + 32'd1;
        end
    end

    // Next state. Memory-wait states share the same rule: a ready completes
    // the access even on the limit cycle; otherwise the limit cycle traps.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        wait_cycle  = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (!hold) begin
                    if (mem_ready) begin
                        state_d = DECODE;
                    end else if (limit_hit) begin
                        state_d     = TRAP;
                        set_timeout = 1'b1;
                    end else begin
                        wait_cycle = 1'b1;
                    end
                end
            end
            DECODE: begin
                unique case (op)
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d     = TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: state_d = (op == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ: begin
                if (mem_ready) begin
                    state_d = MEM_WB;
                end else if (limit_hit) begin
                    state_d     = TRAP;
                    set_timeout = 1'b1;
                end else begin
                    wait_cycle = 1'b1;
                end
            end
            MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end else if (limit_hit) begin
                    state_d     = TRAP;
                    set_timeout = 1'b1;
                end else begin
                    wait_cycle = 1'b1;
                end
            end
            EXECUTE: state_d = ALU_WB;
            MEM_WB, ALU_WB, BRANCH, JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase
    end

    // Outputs. Reset is in this path so that asserting rst_n drops every
    // strobe at once, before any clock edge.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        pc_source     = PC_SRC_ALU;
        alu_src_b     = ALU_B_REG;
        alu_op        = ALU_OP_ADD;
        if (rst_n) begin
            unique case (state_q)
                FETCH: begin
                    alu_src_b = ALU_B_FOUR;
                    if (!hold) begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            ir_write = 1'b1;
                            pc_write = 1'b1;
                        end
                    end
                end
                DECODE: alu_src_b = ALU_B_SHIMM;
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALU_B_IMM;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_FUNCT;
                end
                ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_OP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PC_SRC_ALUOUT;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PC_SRC_JUMP;
                end
                default: ;
            endcase
        end
    end

    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
    assign instr_count = instr_count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [5:0]  op;
  logic        mem_ready, hold;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic        illegal_op, mem_timeout;
  logic [31:0] instr_count;
  logic [3:0]  state_dbg;
  logic [15:0] strobes;

  int checks   = 0;
  int failures = 0;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .mem_ready     (mem_ready),
    .hold          (hold),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .pc_source     (pc_source),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .illegal_op    (illegal_op),
    .mem_timeout   (mem_timeout),
    .instr_count   (instr_count),
    .state_dbg     (state_dbg)
  );

  // strobe vector: pcw pcwc iord mr mw m2r irw rd rw asa | pcs | asb | aop
  assign strobes = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                    mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a,
                    pc_source, alu_src_b, alu_op};

  localparam logic [15:0] V_ZERO       = 16'b0000000000_00_00_00;
  localparam logic [15:0] V_FETCH_RDY  = 16'b1001001000_00_01_00;
  localparam logic [15:0] V_FETCH_WAIT = 16'b0001000000_00_01_00;
  localparam logic [15:0] V_FETCH_HOLD = 16'b0000000000_00_01_00;
  localparam logic [15:0] V_DECODE     = 16'b0000000000_00_11_00;
  localparam logic [15:0] V_MEM_ADDR   = 16'b0000000001_00_10_00;
  localparam logic [15:0] V_MEM_READ   = 16'b0011000000_00_00_00;
  localparam logic [15:0] V_MEM_WB     = 16'b0000010010_00_00_00;
  localparam logic [15:0] V_MEM_WRITE  = 16'b0010100000_00_00_00;
  localparam logic [15:0] V_EXECUTE    = 16'b0000000001_00_00_10;
  localparam logic [15:0] V_ALU_WB     = 16'b0000000110_00_00_00;
  localparam logic [15:0] V_BRANCH     = 16'b0100000001_01_00_01;
  localparam logic [15:0] V_JUMP       = 16'b1000000000_10_00_00;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2,
                         S_MEM_READ = 4'd3, S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5,
                         S_EXECUTE = 4'd6, S_ALU_WB = 4'd7, S_BRANCH = 4'd8,
                         S_JUMP = 4'd9, S_TRAP = 4'd10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already applied: checks the current
  // state and strobes, then advances one clock.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] v);
    #1;
    chk({tag, "_state"}, 32'(state_dbg), 32'(st));
    chk({tag, "_strobes"}, 32'(strobes), 32'(v));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_state"}, 32'(state_dbg), 32'(S_FETCH));
    chk({tag, "_rst_strobes"}, 32'(strobes), 32'(V_ZERO));
    chk({tag, "_rst_illegal"}, 32'(illegal_op), 32'd0);
    chk({tag, "_rst_timeout"}, 32'(mem_timeout), 32'd0);
    chk({tag, "_rst_count"}, instr_count, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    op        = 6'b000000;
    mem_ready = 1'b1;
    hold      = 1'b0;
    #3;
    chk("reset_state", 32'(state_dbg), 32'(S_FETCH));
    chk("reset_strobes", 32'(strobes), 32'(V_ZERO));
    chk("reset_count", instr_count, 32'd0);
    chk("reset_flags", {30'd0, illegal_op, mem_timeout}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // lw with immediate memory: 5 cycles
    op = 6'b100011;
    cyc("lw_fetch", S_FETCH, V_FETCH_RDY);
    cyc("lw_decode", S_DECODE, V_DECODE);
    cyc("lw_addr", S_MEM_ADDR, V_MEM_ADDR);
    cyc("lw_read", S_MEM_READ, V_MEM_READ);
    cyc("lw_wb", S_MEM_WB, V_MEM_WB);
    chk("lw_count", instr_count, 32'd1);

    // R-type, beq, j
    op = 6'b000000;
    cyc("r_fetch", S_FETCH, V_FETCH_RDY);
    cyc("r_decode", S_DECODE, V_DECODE);
    cyc("r_exec", S_EXECUTE, V_EXECUTE);
    cyc("r_wb", S_ALU_WB, V_ALU_WB);
    op = 6'b000100;
    cyc("beq_fetch", S_FETCH, V_FETCH_RDY);
    cyc("beq_decode", S_DECODE, V_DECODE);
    cyc("beq_branch", S_BRANCH, V_BRANCH);
    op = 6'b000010;
    cyc("j_fetch", S_FETCH, V_FETCH_RDY);
    cyc("j_decode", S_DECODE, V_DECODE);
    cyc("j_jump", S_JUMP, V_JUMP);
    chk("rbj_count", instr_count, 32'd4);

    // sw with ready delayed 3 cycles: mem_write held 4 cycles
    op = 6'b101011;
    cyc("sw_fetch", S_FETCH, V_FETCH_RDY);
    cyc("sw_decode", S_DECODE, V_DECODE);
    cyc("sw_addr", S_MEM_ADDR, V_MEM_ADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("sw_wait", S_MEM_WRITE, V_MEM_WRITE);
    chk("sw_no_retire_yet", instr_count, 32'd4);
    mem_ready = 1'b1;
    cyc("sw_done", S_MEM_WRITE, V_MEM_WRITE);
    chk("sw_count", instr_count, 32'd5);
    chk("sw_no_timeout", 32'(mem_timeout), 32'd0);
    chk("sw_back_fetch", 32'(state_dbg), 32'(S_FETCH));

    // fetch ready on the 15th cycle: completion wins
    op = 6'b000000;
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) cyc("late_wait", S_FETCH, V_FETCH_WAIT);
    mem_ready = 1'b1;
    cyc("late_ready", S_FETCH, V_FETCH_RDY);
    chk("late_decode", 32'(state_dbg), 32'(S_DECODE));
    chk("late_no_timeout", 32'(mem_timeout), 32'd0);
    cyc("late_decode2", S_DECODE, V_DECODE);
    cyc("late_exec", S_EXECUTE, V_EXECUTE);
    cyc("late_wb", S_ALU_WB, V_ALU_WB);
    chk("late_count", instr_count, 32'd6);

    // fetch never ready: trap after 15 wait cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc("to_wait", S_FETCH, V_FETCH_WAIT);
    chk("to_flag", 32'(mem_timeout), 32'd1);
    chk("to_illegal_clear", 32'(illegal_op), 32'd0);
    mem_ready = 1'b1;
    cyc("to_trap1", S_TRAP, V_ZERO);
    cyc("to_trap2", S_TRAP, V_ZERO);
    chk("to_count_frozen", instr_count, 32'd6);
    reset_pulse("to");

    // illegal opcode
    op = 6'b111111;
    cyc("ill_fetch", S_FETCH, V_FETCH_RDY);
    cyc("ill_decode", S_DECODE, V_DECODE);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    chk("ill_no_timeout", 32'(mem_timeout), 32'd0);
    cyc("ill_trap1", S_TRAP, V_ZERO);
    cyc("ill_trap2", S_TRAP, V_ZERO);
    reset_pulse("ill");

    // reset in the middle of a store, then hold in FETCH
    op = 6'b101011;
    cyc("mid_fetch", S_FETCH, V_FETCH_RDY);
    cyc("mid_decode", S_DECODE, V_DECODE);
    cyc("mid_addr", S_MEM_ADDR, V_MEM_ADDR);
    mem_ready = 1'b0;
    cyc("mid_write", S_MEM_WRITE, V_MEM_WRITE);
    #1;
    chk("mid_mw_before", 32'(mem_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_mw_dropped", 32'(mem_write), 32'd0);
    chk("mid_strobes", 32'(strobes), 32'(V_ZERO));
    chk("mid_state", 32'(state_dbg), 32'(S_FETCH));
    chk("mid_count", instr_count, 32'd0);
    hold = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("hold", S_FETCH, V_FETCH_HOLD);
    hold = 1'b0;
    op = 6'b000000;
    cyc("hold_release", S_FETCH, V_FETCH_RDY);
    chk("hold_decode", 32'(state_dbg), 32'(S_DECODE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
